// File: rtl/ball_motion_if.sv
// Ball motion bus: block/paddle hit inputs and start/endgame controls in,
// registered and predicted ball position plus state flags out.
interface ball_motion_if;
  logic       start;
  logic       hit_up;
  logic       hit_down;
  logic       hit_left;
  logic       hit_right;
  logic       hit_bar;
  logic       endgame;
  logic [9:0] x_ball;
  logic [9:0] y_ball;
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic       moving;
  logic       lose;

  modport master (
    output start, hit_up, hit_down, hit_left, hit_right, hit_bar, endgame,
    input  x_ball, y_ball, next_x, next_y, moving, lose
  );

  modport slave (
    input  start, hit_up, hit_down, hit_left, hit_right, hit_bar, endgame,
    output x_ball, y_ball, next_x, next_y, moving, lose
  );
endinterface

// File: rtl/ball_motion.sv
// Breakout ball motion controller: steps the ball once per movement tick and
// reflects it off walls, paddle and blocks, publishing current and next position.
module ball_motion #(
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 400,
  parameter int R_BALL   = 8,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 250000
) (
  input  logic         clock,
  input  logic         reset,
  ball_motion_if.slave bus
);

  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [9:0] X_INIT_V   = 10'(X_INIT);
  localparam logic [9:0] Y_INIT_V   = 10'(Y_INIT);
  localparam logic [9:0] STEP_V     = 10'(STEP);
  localparam logic [9:0] EDGE_LO    = 10'(R_BALL);
  localparam logic [9:0] RIGHT_LIM  = 10'(H_RES - 1 - R_BALL);
  localparam logic [9:0] BOTTOM_LIM = 10'(V_RES - 1 - R_BALL);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    LOST = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic             moving_q, moving_d, lose_q, lose_d;
  logic             eff_dx, eff_dy, in_move, tick;
  logic [9:0]       step_x, step_y;

  assign in_move = (state_q == MOVE);
  assign tick    = in_move && (cnt_q == TICK_LAST);

  // Hits override walls so a ball never steps into a block; first match wins per axis
  always_comb begin
    eff_dx = dir_x_q;
    if (bus.hit_left) eff_dx = 1'b0;
    else if (bus.hit_right) eff_dx = 1'b1;
    else if (x_q <= EDGE_LO) eff_dx = 1'b1;
    else if (x_q >= RIGHT_LIM) eff_dx = 1'b0;
    else eff_dx = dir_x_q;

    eff_dy = dir_y_q;
    if (bus.hit_bar) eff_dy = 1'b0;
    else if (bus.hit_up) eff_dy = 1'b0;
    else if (bus.hit_down) eff_dy = 1'b1;
    else if (y_q <= EDGE_LO) eff_dy = 1'b1;
    else eff_dy = dir_y_q;
  end

  assign step_x = eff_dx ? (x_q + STEP_V) : (x_q - STEP_V);
  assign step_y = eff_dy ? (y_q + STEP_V) : (y_q - STEP_V);

  // Next-state, counter, position and direction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.endgame) state_d = LOST;
        else if (bus.start) state_d = MOVE;
        else state_d = IDLE;
      end
      MOVE: begin
        cnt_d   = tick ? '0 : (cnt_q + CNT_W'(1));
        dir_x_d = eff_dx;
        dir_y_d = eff_dy;
        // Loss and endgame both suppress the step taken on this cycle
        if (bus.endgame) begin
          state_d = LOST;
        end else if (tick && (y_q >= BOTTOM_LIM) && !bus.hit_bar) begin
          state_d = LOST;
        end else if (tick) begin
          x_d = step_x;
          y_d = step_y;
        end else begin
          state_d = MOVE;
        end
      end
      LOST: begin
        if (bus.start) begin
          state_d = IDLE;
          cnt_d   = '0;
          x_d     = X_INIT_V;
          y_d     = Y_INIT_V;
          dir_x_d = 1'b1;
          dir_y_d = 1'b0;
        end else begin
          state_d = LOST;
        end
      end
      default: state_d = IDLE;
    endcase
    moving_d = (state_d == MOVE);
    lose_d   = (state_d == LOST);
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      x_q      <= X_INIT_V;
      y_q      <= Y_INIT_V;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b0;
      moving_q <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      moving_q <= moving_d;
      lose_q   <= lose_d;
    end
  end

  assign bus.x_ball = x_q;
  assign bus.y_ball = y_q;
  assign bus.next_x = in_move ? step_x : x_q;
  assign bus.next_y = in_move ? step_y : y_q;
  assign bus.moving = moving_q;
  assign bus.lose   = lose_q;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios plus randomized hits,
// all compared against a behavioural model of the ball kept in plain integers.
module tb_ball_motion;
  localparam int TD = 4;
  localparam int X0 = 320;
  localparam int Y0 = 400;
  localparam int R  = 8;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int ST = 1;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_LOST = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ball_motion_if bus();

  ball_motion #(
    .X_INIT(X0), .Y_INIT(Y0), .R_BALL(R), .H_RES(H), .V_RES(V),
    .STEP(ST), .TICK_DIV(TD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model of the ball
  int m_x, m_y, m_mode, m_clocks;
  bit m_dx, m_dy;

  function automatic bit eff_dx();
    if (bus.hit_left) return 1'b0;
    if (bus.hit_right) return 1'b1;
    if (m_x <= R) return 1'b1;
    if (m_x >= H - 1 - R) return 1'b0;
    return m_dx;
  endfunction

  function automatic bit eff_dy();
    if (bus.hit_bar) return 1'b0;
    if (bus.hit_up) return 1'b0;
    if (bus.hit_down) return 1'b1;
    if (m_y <= R) return 1'b1;
    return m_dy;
  endfunction

  function automatic int exp_nx();
    if (m_mode != M_MOVE) return m_x;
    return eff_dx() ? m_x + ST : m_x - ST;
  endfunction

  function automatic int exp_ny();
    if (m_mode != M_MOVE) return m_y;
    return eff_dy() ? m_y + ST : m_y - ST;
  endfunction

  task automatic drive(input bit st, input bit up, input bit dn, input bit lf,
                       input bit rt, input bit bar, input bit eg);
    bus.start = st; bus.hit_up = up; bus.hit_down = dn; bus.hit_left = lf;
    bus.hit_right = rt; bus.hit_bar = bar; bus.endgame = eg;
  endtask

  // one clock: advance the model with the inputs present at the edge
  task automatic clk_step();
    bit dx, dy, tick;
    int nx, ny;
    @(posedge clock);
    dx = eff_dx(); dy = eff_dy(); nx = exp_nx(); ny = exp_ny();
    tick = ((m_clocks % TD) == TD - 1);
    if (reset) begin
      m_x = X0; m_y = Y0; m_dx = 1'b1; m_dy = 1'b0; m_mode = M_IDLE; m_clocks = 0;
    end else if (m_mode == M_IDLE) begin
      m_clocks = 0;
      if (bus.endgame) m_mode = M_LOST;
      else if (bus.start) m_mode = M_MOVE;
    end else if (m_mode == M_MOVE) begin
      m_dx = dx; m_dy = dy; m_clocks++;
      if (bus.endgame) m_mode = M_LOST;
      else if (tick && m_y >= V - 1 - R && !bus.hit_bar) m_mode = M_LOST;
      else if (tick) begin m_x = nx; m_y = ny; end
    end else if (bus.start) begin
      m_x = X0; m_y = Y0; m_dx = 1'b1; m_dy = 1'b0; m_mode = M_IDLE; m_clocks = 0;
    end
    #1;
  endtask

  task automatic run_until(input int axis, input int target, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if ((axis == 0 ? m_x : m_y) == target) begin ok = 1'b1; break; end
      clk_step();
    end
    if ((axis == 0 ? m_x : m_y) == target) ok = 1'b1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    clk_step(); clk_step();
    reset = 1'b0;
    checks++; if (bus.x_ball !== 10'd320) begin errors++; $display("FAIL reset_x act=%0d exp=320", bus.x_ball); end
    checks++; if (bus.y_ball !== 10'd400) begin errors++; $display("FAIL reset_y act=%0d exp=400", bus.y_ball); end
    checks++; if (bus.moving !== 1'b0 || bus.lose !== 1'b0) begin errors++; $display("FAIL reset_flags act=%b%b exp=00", bus.moving, bus.lose); end
    checks++; if (bus.next_x !== 10'd320 || bus.next_y !== 10'd400) begin errors++; $display("FAIL reset_next act=%0d,%0d exp=320,400", bus.next_x, bus.next_y); end
  endtask

  task automatic test_start();
    drive(1, 0, 0, 0, 0, 0, 0);
    clk_step();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.moving !== 1'b1) begin errors++; $display("FAIL start_moving act=%b exp=1", bus.moving); end
    for (int i = 0; i < TD; i++) begin
      clk_step();
      if (i < TD - 1) begin
        checks++; if (bus.x_ball !== 10'd320 || bus.y_ball !== 10'd400) begin errors++; $display("FAIL early_step act=%0d,%0d exp=320,400", bus.x_ball, bus.y_ball); end
      end else begin
        checks++; if (bus.x_ball !== 10'd321 || bus.y_ball !== 10'd399) begin errors++; $display("FAIL first_step act=%0d,%0d exp=321,399", bus.x_ball, bus.y_ball); end
      end
    end
    checks++; if (bus.next_x !== 10'd322 || bus.next_y !== 10'd398) begin errors++; $display("FAIL first_next act=%0d,%0d exp=322,398", bus.next_x, bus.next_y); end
  endtask

  task automatic test_right_wall();
    bit ok;
    run_until(0, 631, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wall_timeout act=%0d exp=631", m_x); end
    checks++; if (bus.x_ball !== 10'd631 || bus.y_ball !== 10'(m_y)) begin errors++; $display("FAIL wall_pos act=%0d,%0d exp=631,%0d", bus.x_ball, bus.y_ball, m_y); end
    checks++; if (bus.next_x !== 10'd630) begin errors++; $display("FAIL wall_next act=%0d exp=630", bus.next_x); end
    for (int i = 0; i < TD; i++) clk_step();
    checks++; if (bus.x_ball !== 10'd630) begin errors++; $display("FAIL wall_bounce act=%0d exp=630", bus.x_ball); end
  endtask

  task automatic test_hit_up();
    bit ok;
    drive(0, 0, 1, 0, 0, 0, 0);
    clk_step();
    drive(0, 0, 0, 0, 0, 0, 0);
    run_until(1, 200, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hitup_timeout act=%0d exp=200", m_y); end
    checks++; if (bus.next_y !== 10'd201) begin errors++; $display("FAIL hitup_down_dir act=%0d exp=201", bus.next_y); end
    drive(0, 1, 0, 0, 0, 0, 0);
    #1;
    checks++; if (bus.next_y !== 10'd199) begin errors++; $display("FAIL hitup_next act=%0d exp=199", bus.next_y); end
    for (int i = 0; i < TD; i++) clk_step();
    checks++; if (bus.y_ball !== 10'd199 || bus.x_ball !== 10'(m_x)) begin errors++; $display("FAIL hitup_step act=%0d,%0d exp=%0d,199", bus.x_ball, bus.y_ball, m_x); end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_hit_lr();
    bit ok;
    run_until(0, 100, 3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hitlr_timeout act=%0d exp=100", m_x); end
    drive(0, 0, 0, 0, 1, 0, 0);
    #1;
    checks++; if (bus.next_x !== 10'd101) begin errors++; $display("FAIL hitright_next act=%0d exp=101", bus.next_x); end
    clk_step();
    drive(0, 0, 0, 1, 1, 0, 0);
    #1;
    checks++; if (bus.next_x !== 10'd99) begin errors++; $display("FAIL hitleft_prio act=%0d exp=99", bus.next_x); end
    for (int i = 0; i < TD - 1; i++) clk_step();
    checks++; if (bus.x_ball !== 10'd99 || bus.y_ball !== 10'(m_y)) begin errors++; $display("FAIL hitlr_step act=%0d,%0d exp=99,%0d", bus.x_ball, bus.y_ball, m_y); end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_loss();
    bit ok;
    int xs;
    reset = 1'b1; clk_step(); reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0); clk_step();
    drive(0, 0, 1, 0, 0, 0, 0); clk_step();
    drive(0, 0, 0, 0, 0, 0, 0);
    run_until(1, 471, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL loss_timeout act=%0d exp=471", m_y); end
    xs = m_x;
    for (int i = 0; i < TD - 1; i++) clk_step();
    checks++; if (bus.lose !== 1'b0) begin errors++; $display("FAIL loss_early act=%b exp=0", bus.lose); end
    clk_step();
    checks++; if (bus.lose !== 1'b1 || bus.moving !== 1'b0) begin errors++; $display("FAIL loss_flag act=%b%b exp=01", bus.moving, bus.lose); end
    for (int i = 0; i < 3; i++) clk_step();
    checks++; if (bus.y_ball !== 10'd471 || bus.x_ball !== 10'(xs)) begin errors++; $display("FAIL loss_frozen act=%0d,%0d exp=%0d,471", bus.x_ball, bus.y_ball, xs); end
    checks++; if (bus.next_x !== bus.x_ball || bus.next_y !== 10'd471) begin errors++; $display("FAIL loss_next act=%0d,%0d exp=%0d,471", bus.next_x, bus.next_y, bus.x_ball); end
    drive(1, 0, 0, 0, 0, 0, 0); clk_step();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.x_ball !== 10'd320 || bus.y_ball !== 10'd400 || bus.lose !== 1'b0 || bus.moving !== 1'b0) begin
      errors++; $display("FAIL reload act=%0d,%0d,%b%b exp=320,400,00", bus.x_ball, bus.y_ball, bus.moving, bus.lose);
    end
  endtask

  task automatic test_endgame();
    drive(1, 0, 0, 0, 0, 0, 0); clk_step();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2 * TD + 2; i++) clk_step();
    drive(0, 0, 0, 0, 0, 0, 1); clk_step();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.lose !== 1'b1 || bus.x_ball !== 10'd322 || bus.y_ball !== 10'd398) begin
      errors++; $display("FAIL endgame act=%b,%0d,%0d exp=1,322,398", bus.lose, bus.x_ball, bus.y_ball);
    end
    clk_step(); clk_step();
    checks++; if (bus.x_ball !== 10'd322 || bus.y_ball !== 10'd398) begin errors++; $display("FAIL endgame_hold act=%0d,%0d exp=322,398", bus.x_ball, bus.y_ball); end
    reset = 1'b1; clk_step(); reset = 1'b0;
    checks++; if (bus.x_ball !== 10'd320 || bus.y_ball !== 10'd400 || bus.lose !== 1'b0 || bus.moving !== 1'b0) begin
      errors++; $display("FAIL endgame_reset act=%0d,%0d,%b%b exp=320,400,00", bus.x_ball, bus.y_ball, bus.moving, bus.lose);
    end
    drive(1, 0, 0, 0, 0, 0, 0); clk_step();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TD; i++) clk_step();
    checks++; if (bus.x_ball !== 10'd321 || bus.y_ball !== 10'd399) begin errors++; $display("FAIL reset_dir act=%0d,%0d exp=321,399", bus.x_ball, bus.y_ball); end
  endtask

  task automatic test_random();
    bit up, dn, lf, rt, bar;
    reset = 1'b1; clk_step(); reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      up  = ($urandom_range(0, 11) == 0) && (m_y > R + 2);
      dn  = ($urandom_range(0, 11) == 0);
      lf  = ($urandom_range(0, 11) == 0) && (m_x > R + 2);
      rt  = ($urandom_range(0, 11) == 0) && (m_x < H - 3 - R);
      bar = ($urandom_range(0, 7) == 0) && (m_y > 100);
      drive($urandom_range(0, 31) == 0, up, dn, lf, rt, bar, $urandom_range(0, 299) == 0);
      #1;
      checks++; if (bus.next_x !== 10'(exp_nx()) || bus.next_y !== 10'(exp_ny())) begin
        errors++; $display("FAIL rand_next cyc=%0d act=%0d,%0d exp=%0d,%0d", i, bus.next_x, bus.next_y, exp_nx(), exp_ny());
      end
      clk_step();
      checks++; if (bus.x_ball !== 10'(m_x) || bus.y_ball !== 10'(m_y) ||
                    bus.moving !== (m_mode == M_MOVE) || bus.lose !== (m_mode == M_LOST)) begin
        errors++; $display("FAIL rand_state cyc=%0d act=%0d,%0d,%b%b exp=%0d,%0d,%0d", i, bus.x_ball, bus.y_ball,
                           bus.moving, bus.lose, m_x, m_y, m_mode);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_x = X0; m_y = Y0; m_dx = 1'b1; m_dy = 1'b0; m_mode = M_IDLE; m_clocks = 0;
    test_reset();
    test_start();
    test_right_wall();
    test_hit_up();
    test_hit_lr();
    test_loss();
    test_endgame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ball_motion.md
# ball_motion

Ball motion controller for the Breakout datapath. It owns the ball position and direction and advances the ball one step per movement tick. It reflects the ball off the screen walls, the paddle and the blocks, and it publishes both the current and the predicted next position. It sits directly upstream of every block instance: it drives their x_ball/y_ball/next_x/next_y, and it consumes their OR-reduced hit_block_up/down/left/right and endgame outputs.

## Interface
- X_INIT, 320: ball centre x after reset/reload
- Y_INIT, 400: ball centre y after reset/reload
- R_BALL, 8: ball radius in pixels
- H_RES, 640: screen width
- V_RES, 480: screen height
- STEP, 1: pixels moved per tick on each axis; must satisfy 1 ≤ STEP ≤ R_BALL
- TICK_DIV, 250000: clocks per movement tick; must be ≥ 2

- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  level or pulse; launches the ball, or reloads it after a loss
- hit_up  in  1  OR of all blocks' hit_block_up (ball sits above a block)
- hit_down  in  1  OR of hit_block_down
- hit_left  in  1  OR of hit_block_left
- hit_right  in  1  OR of hit_block_right
- hit_bar  in  1  ball touching top face of paddle
- endgame  in  1  OR of all blocks' endgame
- x_ball  out  10  registered ball centre x
- y_ball  out  10  registered ball centre y
- next_x  out  10  combinational position x after next step
- next_y  out  10  combinational position y after next step
- moving  out  1  high in MOVE state
- lose  out  1  high in LOST state

## Operation
- States: IDLE, MOVE, LOST. Reset enters IDLE.
- Reset values:
  - x_ball=X_INIT, y_ball=Y_INIT
  - dir_x=1 (right), dir_y=0 (up)
  - tick counter=0, moving=0, lose=0
- IDLE:
  - Position and direction hold.
  - start=1 moves to MOVE on the next clock.
  - The tick counter is held at 0.
- MOVE:
  - The tick counter increments each clock and wraps at TICK_DIV-1. The tick fires on the wrap cycle.
  - Effective direction is combinational: start from the registered dir_x/dir_y, then apply overrides in this priority order, each axis independently:
    - x axis, first match wins: hit_left → dir_x=0; hit_right → dir_x=1; x_ball ≤ R_BALL → 1; x_ball ≥ H_RES-1-R_BALL → 0.
    - y axis, first match wins: hit_bar → dir_y=0; hit_up → 0; hit_down → 1; y_ball ≤ R_BALL → 1.
  - dir_x/dir_y register the effective direction every MOVE clock. Overrides are absolute assignments, so a hit level held for many clocks is harmless.
  - next_x = x_ball ± STEP and next_y = y_ball ± STEP, both using the effective direction. In IDLE/LOST, next_x=x_ball and next_y=y_ball.
  - On a tick cycle, x_ball←next_x and y_ball←next_y.
  - Loss: on a tick cycle with y_ball ≥ V_RES-1-R_BALL and hit_bar=0, positions do not update and the block moves to LOST.
  - endgame=1 in any state except LOST moves to LOST on the next clock.
- LOST:
  - Position frozen, lose=1.
  - start=1 reloads X_INIT/Y_INIT, dir_x=1, dir_y=0, clears the counter and goes to IDLE.
- Arithmetic is 10-bit unsigned. Wall clamps plus STEP ≤ R_BALL guarantee no underflow or overflow, so no wrap handling is required.
- Reset has priority over everything, in any state and mid-tick.

## Timing
- Direction responds to a hit or wall in the same cycle (combinational into next_x/next_y). It is registered at the following clock edge.
- Position changes exactly once per TICK_DIV clocks while in MOVE. The first move happens TICK_DIV clocks after entering MOVE.
- State outputs moving and lose are registered and valid one clock after the state transition.
- Simultaneous tick and hit: the step uses the reflected direction, so the ball never steps into a block.
- Simultaneous endgame and tick: LOST wins and no position update occurs.

## Test plan
- TICK_DIV=4, reset then start. Required:
  - moving=1 one clock after start.
  - x_ball=321, y_ball=399 after 4 further clocks.
  - next_x=322, next_y=398 thereafter.
- Force x_ball toward the right wall (x=631, dir_x=1) by running MOVE. Required: on the tick at x=631, next_x=630 and x_ball becomes 630.
- Hold hit_up=1 while dir_y=1 and y_ball=200. Required: next_y=199 in the same cycle, and y_ball=199 at the tick.
- Assert hit_left and hit_right together with dir_x=1 at x=100. Required: dir_x=0 (hit_left priority) and x_ball becomes 99.
- Ball descending to y=471 with hit_bar=0. Required:
  - lose=1 one clock after the tick; position frozen.
  - start then restores x=320, y=400, lose=0, IDLE.
- Assert endgame mid-tick (counter=2). Required:
  - LOST next clock; no position step.
  - reset asserted afterwards restores all reset values in one clock.
